// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle (shift-add multiply,
// restoring divide). Handshake is start/busy/done; done is a one-cycle pulse.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result,
  output logic [1:0]      dbg_state
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, result_q, result_d;

  logic              accept, a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf, div_ge;
  logic [XLEN-1:0]   a_mag, b_mag, hi_n, lo_n, quo, rem, fin;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [PW-1:0]     prod, prod_s;

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign Result    = result_q;
  assign dbg_state = state_q;

  // Operand decode and magnitude conversion at accept time.
  always_comb begin
    accept   = start && !kill && (ALUOp == 2'b10) && (Funct7 == 7'b0000001) &&
               (state_q != S_RUN);
    a_sgn    = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    b_sgn    = Funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    a_neg    = a_sgn && SrcA[XLEN-1];
    b_neg    = b_sgn && SrcB[XLEN-1];
    a_mag    = a_neg ? (~SrcA + XLEN'(1)) : SrcA;
    b_mag    = b_neg ? (~SrcB + XLEN'(1)) : SrcB;
    is_div   = Funct3[2];
    div_zero = is_div && (SrcB == '0);
    div_ovf  = is_div && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
  end

  // One iteration step; hi/lo double as {acc, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    if (op_q[2]) begin
      hi_n = div_ge ? (div_shift[XLEN-1:0] - mcand_q) : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? (~prod + PW'(1)) : prod;
    quo    = neg_q ? (~lo_n + XLEN'(1)) : lo_n;
    rem    = neg_q ? (~hi_n + XLEN'(1)) : hi_n;
    case (op_q)
      3'b000:                 fin = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[PW-1:XLEN];
      3'b100, 3'b101:         fin = quo;
      default:                fin = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    if (kill) begin
      state_d = S_IDLE;
    end else if (state_q == S_RUN) begin
      hi_d = hi_n;
      lo_d = lo_n;
      if (cnt_q == CNT_W'(XLEN - 1)) begin
        result_d = fin;
        state_d  = S_DONE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      state_d = S_IDLE;
      if (accept) begin
        op_d    = Funct3;
        // REM takes the dividend's sign; everything else the product of signs.
        neg_d   = (Funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
        cnt_d   = '0;
        hi_d    = '0;
        lo_d    = is_div ? a_mag : b_mag;
        mcand_d = is_div ? b_mag : a_mag;
        if (div_zero) begin
          result_d = Funct3[1] ? SrcA : '1;
          state_d  = S_DONE;
        end else if (div_ovf) begin
          result_d = Funct3[1] ? '0 : MIN_NEG;
          state_d  = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases, handshake/kill/reset scenarios
// and randomized ops checked against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  ALUOp = 2'b10;
  logic [6:0]  Funct7 = 7'b0000001;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        busy, done;
  logic [31:0] Result;
  logic [1:0]  dbg_state;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kill(kill),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .busy(busy), .done(done), .Result(Result), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 0;
    return 32;
  endfunction

  // Drivers: called at a negedge; returns 1ns after the sampling edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    if (push) exp_q.push_back(model(f3, a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
    @(negedge clk);
    issue(f3, a, b, push);
  endtask

  // Waits (bounded) for done; lat counts edges after the accept edge.
  task automatic wait_done(input string tag, output int lat, output bit busy_seen);
    logic [31:0] e;
    lat = -1;
    busy_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (done) begin lat = i; break; end
    end
    check_eq({tag, "_done_seen"}, 32'(lat >= 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check_eq({tag, "_result"}, Result, e);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    bit bs;
    int el;
    el = exp_latency(f3, a, b);
    launch(f3, a, b, 1'b1);
    wait_done(tag, lat, bs);
    check_eq({tag, "_latency"}, 32'(lat), 32'(el));
    if (el == 0) check_eq({tag, "_busy_fast"}, 32'(bs), 32'd0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, d0;
    bit bs;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", Result, 32'd0);
    reset_n = 1'b1;

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD);
    run_op("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulh_min", 3'd1, 32'h80000000, 32'h80000000);
    run_op("mulhsu_m1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2);
    run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op("rand", f3, a, b);
    end

    // start while running is ignored
    launch(3'd0, 32'd7, 32'd3, 1'b1);
    repeat (5) @(negedge clk);
    issue(3'd4, 32'd100, 32'd9, 1'b0);
    d0 = done_cnt;
    wait_done("ign_run", lat, bs);
    check_eq("ign_run_latency", 32'(lat), 32'd27);
    repeat (3) @(negedge clk);
    check_eq("ign_run_pulses", 32'(done_cnt - d0), 32'd1);

    // back-to-back accept in the DONE cycle
    launch(3'd5, 32'd100, 32'd7, 1'b1);
    wait_done("b2b_first", lat, bs);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check_eq("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b_second", lat, bs);
    check_eq("b2b_latency", 32'(lat), 32'd32);
    @(negedge clk);

    // bad decode is not accepted
    @(negedge clk);
    Funct7 = 7'b0000000;
    issue(3'd0, 32'd3, 32'd3, 1'b0);
    Funct7 = 7'b0000001;
    check_eq("f7_busy", 32'(busy), 32'd0);
    check_eq("f7_done", 32'(done), 32'd0);
    @(negedge clk);
    ALUOp = 2'b00;
    issue(3'd0, 32'd3, 32'd3, 1'b0);
    ALUOp = 2'b10;
    check_eq("aluop_busy", 32'(busy), 32'd0);
    check_eq("aluop_done", 32'(done), 32'd0);

    // kill mid-divide keeps the previous Result
    run_op("pre_kill", 3'd5, 32'd100, 32'd7);
    launch(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_eq("kill_busy", 32'(busy), 32'd0);
    check_eq("kill_done", 32'(done), 32'd0);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check_eq("kill_no_pulse", 32'(done_cnt - d0), 32'd0);
    check_eq("kill_result_held", Result, 32'd14);

    // kill together with start
    @(negedge clk);
    kill = 1'b1;
    issue(3'd0, 32'd5, 32'd5, 1'b0);
    kill = 1'b0;
    check_eq("kill_start_busy", 32'(busy), 32'd0);
    check_eq("kill_start_done", 32'(done), 32'd0);

    // async reset mid-multiply
    launch(3'd0, 32'd5, 32'd6, 1'b0);
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_result", Result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    check_eq("arst_no_pulse", 32'(done_cnt - d0), 32'd0);
    run_op("post_rst_mul", 3'd0, 32'd3, 32'd4);
    check_eq("post_rst_const", Result, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
